// File: rtl/regfile_dumper_pkg.sv
// Shared definitions for the register-file dumper: FSM state encoding and
// byte-counter sizing helpers.
package regfile_dumper_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        FIN  = 3'd3,
        CSUM = 3'd4
    } state_t;

    function automatic int unsigned bytes_per_reg(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Byte counter width; at least one bit even for 8-bit registers.
    function automatic int unsigned cnt_width(input int unsigned data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

endpackage

// File: rtl/regfile_dumper_if.sv
// Valid/ready byte stream from the dumper to the UART TX front end.
interface regfile_dumper_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/regfile_dumper_shifter.sv
// Load/shift-by-8 register holding the register being serialised, with a
// byte counter and a flag marking the final byte of the register.
module regfile_dumper_shifter
    import regfile_dumper_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data_in,
    output logic [7:0]        byte_out,
    output logic              last_byte
);

    localparam int unsigned BPR = bytes_per_reg(DATA_W);
    localparam int unsigned CW  = cnt_width(DATA_W);

    logic [DATA_W-1:0] sreg;
    logic [CW-1:0]     cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= data_in;
            cnt  <= '0;
        end else if (shift) begin
            sreg <= sreg >> 8;
            cnt  <= cnt + CW'(1);
        end
    end

    assign byte_out  = sreg[7:0];
    assign last_byte = (cnt == CW'(BPR - 1));

endmodule

// File: rtl/regfile_dumper.sv
// Walks all registers through the debug read port and streams them out
// little-endian; optional trailing XOR byte under REGDUMP_CHECKSUM_EN.
module regfile_dumper
    import regfile_dumper_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    regfile_dumper_if.master  tx
);

    state_t            state;
    state_t            next;
    logic [ADDR_W-1:0] idx;
    logic              load;
    logic              shift;
    logic              last_byte;
    logic              last_reg;
    logic [7:0]        sbyte;

    regfile_dumper_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .data_in   (rd_data),
        .byte_out  (sbyte),
        .last_byte (last_byte)
    );

    assign last_reg = (idx == ADDR_W'(NUM_REGS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // tx_valid is high in SEND, so a handshake there is just tx_ready.
    always_comb begin
        next  = state;
        load  = 1'b0;
        shift = 1'b0;
        case (state)
            IDLE: if (start) next = LOAD;
            LOAD: begin
                load = 1'b1;
                next = SEND;
            end
            SEND: if (tx.tx_ready) begin
                shift = 1'b1;
                if (last_byte) begin
`ifdef REGDUMP_CHECKSUM_EN
                    next = last_reg ? CSUM : LOAD;
`else
                    next = last_reg ? FIN : LOAD;
`endif
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            CSUM: if (tx.tx_ready) next = FIN;
`endif
            FIN:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (state == IDLE && start) begin
            idx <= '0;
        end else if (shift && last_byte && !last_reg) begin
            idx <= idx + ADDR_W'(1);
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (state == IDLE && start) begin
            csum <= '0;
        end else if (shift) begin
            csum <= csum ^ sbyte;
        end
    end

    assign tx.tx_valid = (state == SEND) || (state == CSUM);
    assign tx.tx_data  = (state == SEND) ? sbyte :
                         (state == CSUM) ? csum  : 8'h00;
`else
    assign tx.tx_valid = (state == SEND);
    assign tx.tx_data  = (state == SEND) ? sbyte : 8'h00;
`endif

    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign rd_addr = (state == IDLE) ? '0 : idx;

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench for regfile_dumper: probe tables, directed corner
// sequences and randomized dumps against a byte-stream reference model.
module tb_regfile_dumper;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BPR      = DATA_W / 8;
    localparam int          LIMIT    = 3000;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int          CS_EXTRA = 1;
`else
    localparam int          CS_EXTRA = 0;
`endif
    localparam int TIED_CYCLES = NUM_REGS * (1 + BPR) + 1 + CS_EXTRA;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] regs [NUM_REGS];

    regfile_dumper_if txi ();

    regfile_dumper #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tx      (txi.master)
    );

    always #5 clk = ~clk;

    // Register file model: x0 reads as zero.
    assign rd_data = (rd_addr == '0) ? '0 : regs[rd_addr];

    int n_cmp = 0;
    int n_bad = 0;
    int rmode = 0;
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    int done_cnt;
    int stab_err;
    int stab_checks;

    typedef struct {
        int         pos;
        logic [7:0] exp;
    } probe_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Ready driver: 0 = tied high, 1 = high one cycle in three, 2 = random.
    initial begin
        int unsigned rcnt = 0;
        txi.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       txi.tx_ready = 1'b1;
                1:       txi.tx_ready = (rcnt % 3 == 0);
                default: txi.tx_ready = 1'($urandom_range(0, 1));
            endcase
            rcnt++;
        end
    end

    // Stream monitor: collects handshaken bytes, counts done pulses and
    // watches that a stalled byte neither changes nor disappears.
    initial begin
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data  = '0;
        forever begin
            @(negedge clk);
            if (prev_stall && !rst) begin
                stab_checks++;
                if (!txi.tx_valid || txi.tx_data !== prev_data) stab_err++;
            end
            if (txi.tx_valid && txi.tx_ready) got.push_back(txi.tx_data);
            if (done) done_cnt++;
            prev_stall = txi.tx_valid && !txi.tx_ready;
            prev_data  = txi.tx_data;
        end
    end

    // Reference stream computed straight from register contents.
    task automatic build_exp();
        logic [DATA_W-1:0] v;
        logic [7:0]        x;
        exp_q.delete();
        x = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            v = (i == 0) ? '0 : regs[i];
            for (int b = 0; b < int'(BPR); b++) begin
                exp_q.push_back(v[8*b +: 8]);
                x = x ^ v[8*b +: 8];
            end
        end
        if (CS_EXTRA == 1) exp_q.push_back(x);
    endtask

    task automatic compare_stream(input string tag, input int reps);
        int bad;
        int first;
        int n;
        bad = 0;
        first = -1;
        n = exp_q.size();
        check({tag, "_len"}, got.size(), n * reps);
        for (int i = 0; i < got.size() && i < n * reps; i++) begin
            if (got[i] !== exp_q[i % n]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        check($sformatf("%s_bad_bytes(first at %0d)", tag, first), bad, 0);
    endtask

    task automatic run_dump(input string tag, input int mode, input int restart_at);
        int cyc;
        int first_v;
        bit poked;
        build_exp();
        rmode = mode;
        got.delete();
        done_cnt = 0;
        stab_err = 0;
        stab_checks = 0;
        poked = 0;
        first_v = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        cyc = 1;
        check({tag, "_load_busy"}, busy, 1);
        check({tag, "_load_valid"}, txi.tx_valid, 0);
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (txi.tx_valid && first_v < 0) first_v = cyc;
            if (restart_at >= 0 && !poked && got.size() >= restart_at) begin
                poked = 1;
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_first_valid_cycle"}, first_v, 2);
        if (mode == 0) check({tag, "_load_to_done"}, cyc, TIED_CYCLES);
        check({tag, "_busy_in_fin"}, busy, 1);
        @(negedge clk);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_pulse_once"}, done_cnt, 1);
        check({tag, "_stable"}, stab_err, 0);
        if (mode == 1) check({tag, "_stalls_seen"}, stab_checks > 0, 1);
        compare_stream(tag, 1);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = 32'h1000_0000 + 32'(i);
    endtask

    initial begin
        probe_t t1 [12];
        probe_t t2 [4];
        int     cyc;
        int     n1;

        t1 = '{'{0, 8'h00}, '{1, 8'h00}, '{2, 8'h00}, '{3, 8'h00},
               '{4, 8'h01}, '{5, 8'h00}, '{6, 8'h00}, '{7, 8'h10},
               '{124, 8'h1F}, '{125, 8'h00}, '{126, 8'h00}, '{127, 8'h10}};
        t2 = '{'{20, 8'hEF}, '{21, 8'hBE}, '{22, 8'hAD}, '{23, 8'hDE}};

        rst = 1'b1;
        start = 1'b0;
        fill_ramp();
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", txi.tx_valid, 0);
        check("rst_data", txi.tx_data, 0);
        check("rst_addr", rd_addr, 0);
        #2 rst = 1'b0;

        // Ramp pattern, ready tied high.
        run_dump("ramp", 0, -1);
        foreach (t1[i])
            check($sformatf("ramp_byte%0d", t1[i].pos),
                  (got.size() > t1[i].pos) ? got[t1[i].pos] : 8'hXX, t1[i].exp);

        // Back-pressure one cycle in three.
        regs[5] = 32'hDEAD_BEEF;
        run_dump("stall", 1, -1);
        foreach (t2[i])
            check($sformatf("stall_byte%0d", t2[i].pos),
                  (got.size() > t2[i].pos) ? got[t2[i].pos] : 8'hXX, t2[i].exp);

        // start re-pulsed mid-dump is ignored.
        fill_ramp();
        run_dump("restart", 0, 40);

        // Asynchronous abort in SEND, then a clean dump.
        got.delete();
        rmode = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (!(got.size() >= 57 && txi.tx_valid) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_send", txi.tx_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_valid", txi.tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        #1 rst = 1'b0;
        run_dump("after_abort", 0, -1);

`ifdef REGDUMP_CHECKSUM_EN
        for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = 32'hA5A5_A5A5;
        regs[0] = '0;
        run_dump("csum_a5", 0, -1);
        check("csum_a5_last", (got.size() == 129) ? got[128] : 8'hXX, 8'h00);
        regs[1] = 32'hA5A5_A501;  // low byte changed from A5 to 01
        run_dump("csum_x1", 2, -1);
        check("csum_x1_last", (got.size() == 129) ? got[128] : 8'hXX, 8'hA4);
`endif

        // start held for 3 cycles, then re-requested across done.
        fill_ramp();
        build_exp();
        got.delete();
        done_cnt = 0;
        rmode = 0;
        @(posedge clk); #1 start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("hold_done_seen", done, 1);
        n1 = got.size();
        check("hold_first_len", n1, exp_q.size());
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_start_on_done_ignored", busy, 0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("hold_second_busy", busy, 1);
        check("hold_second_load_valid", txi.tx_valid, 0);
        @(negedge clk);
        check("hold_second_first_valid", txi.tx_valid, 1);
        cyc = 0;
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("hold_second_done_seen", done, 1);
        @(negedge clk);
        check("hold_done_count", done_cnt, 2);
        compare_stream("hold_two_dumps", 2);

        // Randomized contents and random back-pressure.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] = $urandom;
            run_dump($sformatf("rand%0d", r), 2, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
